// File: rtl/seg7_pkg.sv
// seg7_pkg: segment encodings, pattern classes and FSM states shared by the 7-segment readback
package seg7_pkg;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                               7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h7E;
    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_MINUS = 4'hA;
    typedef enum logic [1:0] {CLS_DIGIT, CLS_BLANK, CLS_MINUS, CLS_INVALID} seg_class_t;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: classifies one active-low segment pattern and recovers its numeral value
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0]  seg,
    output seg_class_t  cls,
    output logic [3:0]  val
);
    always_comb begin
        cls = seg == SEG_BLANK ? CLS_BLANK : seg == SEG_MINUS ? CLS_MINUS : CLS_INVALID;
        val = seg == SEG_MINUS ? BCD_MINUS : BCD_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (seg == SEG_DIGIT[i]) begin
                cls = CLS_DIGIT;
                val = 4'(i);
            end
        end
    end
endmodule

// File: rtl/seg7_readback.sv
// seg7_readback: scans captured HEX segment patterns MSD-first, one digit per clock,
// and reports per-digit BCD, binary magnitude, sign and first error position.
module seg7_readback
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_W      = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7*NUM_DIGITS-1:0]       seg_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*NUM_DIGITS-1:0]       bcd_out,
    output logic [BIN_W-1:0]              bin_out,
    output logic                          neg,
    output logic                          err,
    output logic [$clog2(NUM_DIGITS)-1:0] err_pos
);
    localparam int IW = $clog2(NUM_DIGITS);

    if (2.0 ** BIN_W <= 10.0 ** NUM_DIGITS - 1.0) begin : g_width_check
        $error("BIN_W too narrow for NUM_DIGITS decimal digits");
    end

    state_t                  state;
    logic [7*NUM_DIGITS-1:0] shadow;
    logic [IW-1:0]           idx, minus_pos, minus_pos_n, err_pos_n;
    logic [BIN_W-1:0]        acc, acc_n;
    logic [BIN_W+3:0]        prod;
    logic                    seen_num, seen_num_n, neg_n, err_n, bad, lone_minus;
    seg_class_t              cls;
    logic [3:0]              val, nib;
    logic [6:0]              cur;

    assign req_ready = rst_n && state == IDLE;
    assign cur       = shadow[7*idx +: 7];
    assign prod      = {4'b0, acc} * (BIN_W+4)'(10);

    seg7_decode u_dec (.seg(cur), .cls(cls), .val(val));

    always_comb begin
        nib         = BCD_BLANK;
        acc_n       = acc;
        neg_n       = neg;
        seen_num_n  = seen_num;
        minus_pos_n = minus_pos;
        bad         = 1'b0;
        if (cls == CLS_DIGIT) begin
            acc_n      = prod[BIN_W-1:0] + BIN_W'(val);
            seen_num_n = 1'b1;
            nib        = val;
        end else if (cls == CLS_BLANK) begin
            bad = seen_num || neg;
        end else if (cls == CLS_MINUS && !seen_num && !neg) begin
            neg_n       = 1'b1;
            minus_pos_n = idx;
            nib         = BCD_MINUS;
        end else begin
            bad = 1'b1;
        end
        err_n      = err || bad;
        err_pos_n  = bad && !err ? idx : err_pos;
        lone_minus = neg_n && !seen_num_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            idx       <= '0;
            acc       <= '0;
            seen_num  <= 1'b0;
            minus_pos <= '0;
            out_valid <= 1'b0;
            bcd_out   <= '0;
            bin_out   <= '0;
            neg       <= 1'b0;
            err       <= 1'b0;
            err_pos   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    shadow    <= seg_in;
                    idx       <= IW'(NUM_DIGITS - 1);
                    acc       <= '0;
                    seen_num  <= 1'b0;
                    minus_pos <= '0;
                    bcd_out   <= '0;
                    bin_out   <= '0;
                    neg       <= 1'b0;
                    err       <= 1'b0;
                    err_pos   <= '0;
                    state     <= SCAN;
                end
                SCAN: begin
                    bcd_out[4*idx +: 4] <= nib;
                    acc       <= acc_n;
                    neg       <= neg_n;
                    seen_num  <= seen_num_n;
                    minus_pos <= minus_pos_n;
                    err       <= err_n;
                    err_pos   <= err_pos_n;
                    idx       <= idx - 1'b1;
                    // a minus with no numeral after it only becomes an error once the scan ends
                    if (idx == '0) begin
                        err       <= err_n || lone_minus;
                        err_pos   <= !err_n && lone_minus ? minus_pos_n : err_pos_n;
                        bin_out   <= err_n || lone_minus ? '0 : acc_n;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_readback.sv
// tb_seg7_readback: directed vector table plus backpressure and mid-scan reset sequences
module tb_seg7_readback;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [41:0] seg_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] bcd_out;
    logic [19:0] bin_out;
    logic        neg, err;
    logic [2:0]  err_pos;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic [41:0] seg;
        logic [23:0] bcd;
        logic [19:0] bin;
        logic        neg;
        logic        err;
        logic [2:0]  pos;
    } vec_t;

    vec_t vecs[10];

    seg7_readback #(.NUM_DIGITS(6), .BIN_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .seg_in(seg_in), .out_valid(out_valid), .out_ready(out_ready),
        .bcd_out(bcd_out), .bin_out(bin_out), .neg(neg), .err(err), .err_pos(err_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_result(input int n, input vec_t v);
        chk($sformatf("v%0d bcd", n), 64'(bcd_out), 64'(v.bcd));
        chk($sformatf("v%0d bin", n), 64'(bin_out), 64'(v.bin));
        chk($sformatf("v%0d neg", n), 64'(neg), 64'(v.neg));
        chk($sformatf("v%0d err", n), 64'(err), 64'(v.err));
        chk($sformatf("v%0d err_pos", n), 64'(err_pos), 64'(v.pos));
    endtask

    // counts edges from the accept edge until out_valid; expects exactly 6
    task automatic wait_result(input int n);
        int cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
        end
        chk($sformatf("v%0d latency", n), 64'(cyc), 64'd6);
    endtask

    task automatic accept(input logic [41:0] s);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!req_ready) chk("req_ready timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        seg_in = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seg_in = {6{7'h55}};
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [23:0] hb;
        logic [19:0] hbin;
        vecs[0] = '{{7'h4F,7'h12,7'h06,7'h4C,7'h24,7'h20}, 24'h123456, 20'd123456, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{{7'h7F,7'h7F,7'h7F,7'h7E,7'h4C,7'h12}, 24'hFFFA42, 20'd42, 1'b1, 1'b0, 3'd0};
        vecs[2] = '{{7'h4F,7'h12,7'h7F,7'h4C,7'h24,7'h20}, 24'h12F456, 20'd0, 1'b0, 1'b1, 3'd3};
        vecs[3] = '{{7'h4F,7'h12,7'h06,7'h4C,7'h24,7'h55}, 24'h12345F, 20'd0, 1'b0, 1'b1, 3'd0};
        vecs[4] = '{{6{7'h7F}}, 24'hFFFFFF, 20'd0, 1'b0, 1'b0, 3'd0};
        vecs[5] = '{{{5{7'h7F}},7'h7E}, 24'hFFFFFA, 20'd0, 1'b1, 1'b1, 3'd0};
        vecs[6] = '{{7'h7F,7'h7E,7'h7E,7'h4F,7'h12,7'h06}, 24'hFAF123, 20'd0, 1'b1, 1'b1, 3'd3};
        vecs[7] = '{{6{7'h04}}, 24'h999999, 20'd999999, 1'b0, 1'b0, 3'd0};
        vecs[8] = '{{7'h7F,7'h4F,7'h7E,7'h12,7'h7F,7'h01}, 24'hF1F2F0, 20'd0, 1'b0, 1'b1, 3'd3};
        vecs[9] = '{{7'h7F,7'h7E,7'h01,7'h01,7'h0F,7'h00}, 24'hFA0078, 20'd78, 1'b1, 1'b0, 3'd0};

        #12;
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset bcd_out", 64'(bcd_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            accept(vecs[i].seg);
            chk($sformatf("v%0d req_ready busy", i), 64'(req_ready), 64'd0);
            wait_result(i);
            chk_result(i, vecs[i]);
            finish_out();
        end

        // backpressure: result held, then back-to-back request one cycle after handshake
        accept(vecs[0].seg);
        wait_result(100);
        hb = bcd_out;
        hbin = bin_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp req_ready", 64'(req_ready), 64'd0);
            chk("bp bcd stable", 64'(bcd_out), 64'(vecs[0].bcd));
            chk("bp bin stable", 64'(bin_out), 64'(vecs[0].bin));
        end
        req_valid = 1'b1;
        seg_in = vecs[1].seg;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp handshake out_valid", 64'(out_valid), 64'd0);
        chk("bp idle req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp reaccept req_ready", 64'(req_ready), 64'd0);
        wait_result(101);
        chk_result(101, vecs[1]);
        finish_out();

        // reset while idx==3 during scan
        accept(vecs[0].seg);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst bcd_out", 64'(bcd_out), 64'd0);
        chk("rst bin_out", 64'(bin_out), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst neg/err", 64'({neg, err, err_pos}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst release req_ready", 64'(req_ready), 64'd1);
        accept(vecs[2].seg);
        wait_result(102);
        chk_result(102, vecs[2]);
        finish_out();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/seg7_readback.md
Name: seg7_readback

Overview:
- Reverse path of the BCD-to-7-segment drive. Captures the segment patterns driven onto all HEX displays and decodes them back to per-digit BCD and a binary magnitude with sign.
- Used by the calculator's self-check logic, and as a bench monitor, to confirm that what is displayed matches the computed result.
- Scans one digit per clock under a valid/ready request/response handshake.

Parameters:
- NUM_DIGITS, 6: number of 7-segment digits scanned.
- BIN_W, 20: width of binary magnitude output. Elaboration-time assertion: 2**BIN_W > 10**NUM_DIGITS - 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request to decode seg_in
- req_ready  out  1  block idle, request accepted on req_valid&&req_ready
- seg_in  in  7*NUM_DIGITS  segment patterns
  - digit d occupies [7d+6:7d]; digit 0 is least significant
  - within a field, bit 6=a, 5=b, 4=c, 3=d, 2=e, 1=f, 0=g
  - active-low: 0 = segment lit
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- bcd_out  out  4*NUM_DIGITS  per-digit code, same digit ordering as seg_in
  - 0-9 for numerals, 4'hF for blank, 4'hA for minus
- bin_out  out  BIN_W  unsigned magnitude; 0 when err
- neg  out  1  a leading minus was decoded
- err  out  1  illegal display content
- err_pos  out  $clog2(NUM_DIGITS)  index of first offending digit; 0 when err=0

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - out_valid, neg, err, err_pos, bcd_out, bin_out all 0.
  - req_ready=0 while rst_n low; otherwise req_ready = (state==IDLE).
- States:
  - IDLE: on req_valid, capture seg_in into a shadow register; clear accumulator, flags and seen_numeral/seen_minus; idx=NUM_DIGITS-1; go to SCAN.
  - SCAN: each clock, decode shadow[idx], update the result, decrement idx. After idx==0 is processed, go to DONE.
  - DONE: out_valid=1 and all outputs held stable. On out_ready, go to IDLE. There is no same-cycle re-accept; a new request can be accepted the following cycle at the earliest.
- Latency: the accept edge is E0; digits are processed on edges E1..EN; out_valid goes high after EN, i.e. NUM_DIGITS cycles after accept.
- seg_in changes after accept have no effect.
- Pattern classes:
  - numeral 0-9: the exact encodings 7'h01, 4F, 12, 06, 4C, 24, 20, 0F, 00, 04
  - blank: 7'h7F
  - minus: 7'h7E
  - invalid: any other pattern
- Per-digit rules, scanning from the most significant digit:
  - blank before any numeral or minus: leading blank; nibble F; no accumulate.
  - minus with no prior numeral and no prior minus: neg=1; nibble A.
  - numeral: acc = acc*10 + digit; seen_numeral=1; nibble = digit.
  - error cases: blank after a numeral or after a minus, minus after a numeral, second minus, invalid pattern. Set err and latch err_pos (first error only); nibble F; scanning continues.
  - end of scan with neg=1 and no numeral: error, with err_pos = position of the minus.
- All digits blank: not an error; bin_out=0, neg=0, bcd_out all F.
- Output on error: bin_out=0; neg is reported as decoded; err_pos holds the first error.
- acc*10 uses a BIN_W+4 bit intermediate, truncated to BIN_W. Overflow is impossible given the parameter assertion.
- Reset mid-SCAN or in DONE aborts immediately to the reset values. No partial result is emitted.

Decomposition:
- Package seg7_pkg holds:
  - segment constants SEG_DIGIT[0:9], SEG_BLANK=7'h7F, SEG_MINUS=7'h7E
  - BCD_BLANK=4'hF, BCD_MINUS=4'hA
  - a seg_class_t enum {CLS_DIGIT, CLS_BLANK, CLS_MINUS, CLS_INVALID}
  - the FSM state enum {IDLE, SCAN, DONE}
- One combinational sub-module, seg7_decode: 7-bit pattern in, seg_class_t plus a 4-bit value out. It is the exact inverse of the encoder table.

Test Plan:
- Pattern "123456" (fields 4F,12,06,4C,24,20 from digit 5 down) -> after 6 cycles: bcd_out=24'h123456, bin_out=123456, neg=0, err=0.
- Pattern blank,blank,blank,minus,"4","2" -> bcd_out=24'hFFFA42, bin_out=42, neg=1, err=0.
- Pattern "12", blank, "456" (blank at idx 3) -> err=1, err_pos=3, bin_out=0.
- 7'h55 at idx 0, numerals elsewhere -> err=1, err_pos=0.
- All fields 7'h7F -> bcd_out=24'hFFFFFF, bin_out=0, err=0.
- All fields 7'h7F except minus alone at idx 0 -> err=1, err_pos=0.
- Backpressure: hold out_ready=0 for 5 cycles -> outputs stable and req_ready=0. With req_valid held high, the next request is accepted exactly 1 cycle after the out handshake.
- Assert rst_n low at SCAN idx=3 -> outputs zero immediately. After release, req_ready=1, and a fresh request decodes correctly.
